// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_responder_pkg;

   // Responder sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Operation captured when a request is sampled
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // Value returned on data_mem_out for an errored read unless overridden
   localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/data_mem_responder_ram.sv
// Synchronous single-port word RAM with registered read data.
// The array has no reset so it maps onto block RAM; contents survive reset.
module data_ram #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem_q [0:(1<<ADDR_W)-1];

   // Write on we, read the addressed word every cycle (read-before-write)
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory interface. Samples a request in
// IDLE, waits WAIT_CYCLES cycles, then completes with a one-cycle
// mem_ready (and mem_err on a bad access) in the RESP state.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int          ADDR_W      = 10,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] ram_addr,
   input  logic [31:0] data_mem_in,
   output logic [31:0] data_mem_out,
   output logic        mem_ready,
   output logic        mem_err
);

   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : CNT_W'(0);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   op_e                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [31:0]         dout_q, dout_d;

   logic                in_resp;
   logic                req_err;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr_sel;
   logic [31:0]         ram_rdata;
   logic [31:0]         read_val;

   // Out-of-range address or conflicting read+write is an error
   assign req_err = (|ram_addr[31:ADDR_W]) | (mem_rd & mem_wr);

   assign in_resp = (state_q == RESP);

   // In IDLE the RAM is addressed from the live request so a zero-wait
   // read has its data ready in RESP; afterwards the latched address rules.
   assign ram_addr_sel = (state_q == IDLE) ? ram_addr[ADDR_W-1:0] : addr_q;
   assign ram_we       = in_resp & (op_q == OP_WR) & ~err_q;
   assign read_val     = err_q ? ERR_DATA : ram_rdata;

   // Outputs decode from registered state only
   assign mem_ready    = in_resp;
   assign mem_err      = in_resp & err_q;
   assign data_mem_out = (in_resp && op_q == OP_RD) ? read_val : dout_q;

   data_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr_sel),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= OP_RD;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         dout_q  <= dout_d;
      end
   end

   // Next-state logic: sample in IDLE, count in WAIT, complete in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            if (mem_rd | mem_wr) begin
               op_d    = (mem_wr & ~mem_rd) ? OP_WR : OP_RD;
               addr_d  = ram_addr[ADDR_W-1:0];
               wdata_d = data_mem_in;
               err_d   = req_err;
               if (WAIT_CYCLES > 0) begin
                  state_d = WAIT;
                  cnt_d   = CNT_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
            if (op_q == OP_RD) begin
               dout_d = read_val;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: two instances (2 wait states,
// ADDR_W=10, zero ERR_DATA; 0 wait states, ADDR_W=4, nonzero ERR_DATA).
module tb_data_mem_responder;

   typedef struct {
      logic        err;
      bit          chk;
      logic [31:0] data;
      longint      cyc;
      string       name;
   } exp_t;

   localparam int          WAITS [2] = '{2, 0};
   localparam int          AWS   [2] = '{10, 4};
   localparam logic [31:0] ERRDS [2] = '{32'h0000_0000, 32'hDEAD_BEEF};

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd_s   [2];
   logic        wr_s   [2];
   logic [31:0] addr_s [2];
   logic [31:0] din_s  [2];
   logic [31:0] dout_s [2];
   logic        rdy_s  [2];
   logic        err_s  [2];

   longint      cyc = 0;
   int          tests = 0;
   int          fails = 0;
   exp_t        q0[$];
   exp_t        q1[$];
   logic [31:0] model_mem [2][16];
   logic [31:0] last_rd [2];
   bit          last_known [2];

   data_mem_responder #(
      .ADDR_W(10), .WAIT_CYCLES(2), .ERR_DATA(32'h0000_0000)
   ) u_dut0 (
      .clk(clk), .reset(reset), .mem_rd(rd_s[0]), .mem_wr(wr_s[0]),
      .ram_addr(addr_s[0]), .data_mem_in(din_s[0]),
      .data_mem_out(dout_s[0]), .mem_ready(rdy_s[0]), .mem_err(err_s[0])
   );

   data_mem_responder #(
      .ADDR_W(4), .WAIT_CYCLES(0), .ERR_DATA(32'hDEAD_BEEF)
   ) u_dut1 (
      .clk(clk), .reset(reset), .mem_rd(rd_s[1]), .mem_wr(wr_s[1]),
      .ram_addr(addr_s[1]), .data_mem_in(din_s[1]),
      .data_mem_out(dout_s[1]), .mem_ready(rdy_s[1]), .mem_err(err_s[1])
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Pop the oldest expectation for instance k and compare with the DUT
   task automatic check_resp(input int k);
      exp_t e;
      bit   have;
      have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      tests++;
      if (!have) begin
         fails++;
         $display("FAIL unexpected_ready[%0d]: mem_ready=1 at cycle %0d, required no response", k, cyc);
         return;
      end
      e = (k == 0) ? q0.pop_front() : q1.pop_front();
      if (cyc != e.cyc) begin
         fails++;
         $display("FAIL %s[%0d] latency: ready at cycle %0d, required %0d", e.name, k, cyc, e.cyc);
      end
      tests++;
      if (err_s[k] !== e.err) begin
         fails++;
         $display("FAIL %s[%0d] mem_err: got %0b, required %0b", e.name, k, err_s[k], e.err);
      end
      if (e.chk) begin
         tests++;
         if (dout_s[k] !== e.data) begin
            fails++;
            $display("FAIL %s[%0d] data: got %h, required %h", e.name, k, dout_s[k], e.data);
         end
      end
      $display("[TB] inst%0d %s cyc=%0d err=%0b data=%h", k, e.name, cyc, err_s[k], dout_s[k]);
   endtask

   // Monitor: compare whenever either DUT presents mem_ready
   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            if (rdy_s[k] === 1'b1) check_resp(k);
         end
      end
   end

   // Issue one access, record its expected response, hold until mem_ready
   task automatic req(input int k, input bit rd, input bit wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit scr, input string nm);
      exp_t e;
      bit   err;
      int   n;
      @(negedge clk);
      rd_s[k] = rd; wr_s[k] = wr; addr_s[k] = a; din_s[k] = d;
      err    = (a >= (32'd1 << AWS[k])) || (rd && wr);
      e.err  = err;
      e.cyc  = cyc + 1 + WAITS[k];
      e.name = nm;
      e.chk  = 1'b0;
      e.data = '0;
      if (rd && wr) begin
         last_known[k] = 1'b0;
      end else if (rd) begin
         e.chk  = 1'b1;
         e.data = err ? ERRDS[k] : model_mem[k][a[3:0]];
         last_rd[k] = e.data;
         last_known[k] = 1'b1;
      end else begin
         e.chk  = last_known[k];
         e.data = last_rd[k];
         if (!err) model_mem[k][a[3:0]] = d;
      end
      if (k == 0) q0.push_back(e); else q1.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (scr && n == 1) begin
            addr_s[k] = $urandom;
            din_s[k]  = $urandom;
         end
      end while (rdy_s[k] !== 1'b1 && n < 20);
      tests++;
      if (rdy_s[k] !== 1'b1) begin
         fails++;
         $display("FAIL %s[%0d] timeout: no mem_ready within %0d cycles, required one", nm, k, n);
      end
      rd_s[k] = 1'b0;
      wr_s[k] = 1'b0;
   endtask

   initial begin
      int          kind;
      logic [31:0] a;
      bit          rd;
      for (int k = 0; k < 2; k++) begin
         rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; din_s[k] = '0;
         last_rd[k] = '0; last_known[k] = 1'b1;
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         tests++;
         if (rdy_s[k] !== 1'b0 || err_s[k] !== 1'b0 || dout_s[k] !== 32'h0) begin
            fails++;
            $display("FAIL reset_state[%0d]: ready=%0b err=%0b data=%h, required 0 0 00000000",
                     k, rdy_s[k], err_s[k], dout_s[k]);
         end
      end
      reset = 1'b1;

      // Preload every modelled word of both RAMs
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            req(k, 1'b0, 1'b1, 32'(i), (k == 1 && i < 4) ? 32'(10 + i) : $urandom, 1'b0, "preload");
         end
      end

      // Directed cases on the two-wait-state instance
      req(0, 1'b0, 1'b1, 32'd5, 32'hCAFE_0001, 1'b0, "wr5");
      req(0, 1'b1, 1'b0, 32'd5, 32'h0, 1'b0, "rd5");
      req(0, 1'b1, 1'b0, 32'h0000_0400, 32'h0, 1'b0, "rd_oor");
      req(0, 1'b1, 1'b0, 32'd0, 32'h0, 1'b0, "rd0_after_oor");
      req(0, 1'b1, 1'b1, 32'd7, 32'h1234, 1'b0, "rd_wr_both");
      req(0, 1'b1, 1'b0, 32'd7, 32'h0, 1'b0, "rd7_unchanged");
      req(0, 1'b0, 1'b1, 32'd2, 32'h5555_0002, 1'b1, "wr2_scramble");
      req(0, 1'b1, 1'b0, 32'd2, 32'h0, 1'b0, "rd2");

      // Reset during WAIT of a write: nothing commits, outputs clear
      @(negedge clk);
      wr_s[0] = 1'b1; addr_s[0] = 32'd9; din_s[0] = 32'hAAAA_AAAA;
      @(negedge clk);
      reset = 1'b0;
      #1;
      tests++;
      if (rdy_s[0] !== 1'b0 || err_s[0] !== 1'b0 || dout_s[0] !== 32'h0) begin
         fails++;
         $display("FAIL reset_mid_wait: ready=%0b err=%0b data=%h, required 0 0 00000000",
                  rdy_s[0], err_s[0], dout_s[0]);
      end
      wr_s[0] = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         last_rd[k] = '0; last_known[k] = 1'b1;
      end
      req(0, 1'b1, 1'b0, 32'd9, 32'h0, 1'b0, "rd9_after_rst");

      // Zero-wait instance: back-to-back reads and an errored read
      for (int i = 0; i < 4; i++) req(1, 1'b1, 1'b0, 32'(i), 32'h0, 1'b0, "b2b_rd");
      req(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, "rd_oor");
      req(1, 1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, "wr_oor");
      req(1, 1'b1, 1'b0, 32'd0, 32'h0, 1'b0, "rd0_after_wr_oor");

      // Randomized traffic on both instances
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            rd   = ($urandom_range(0, 1) == 1);
            if (kind == 0) begin
               a = $urandom | 32'h0000_0400;
               req(k, rd, ~rd, a, $urandom, 1'b0, "rnd_oor");
            end else if (kind == 1) begin
               req(k, 1'b1, 1'b1, 32'($urandom_range(0, 15)), $urandom, 1'b0, "rnd_both");
            end else if (kind < 6) begin
               req(k, 1'b0, 1'b1, 32'($urandom_range(0, 15)), $urandom,
                   ($urandom_range(0, 3) == 0), "rnd_wr");
            end else begin
               req(k, 1'b1, 1'b0, 32'($urandom_range(0, 15)), 32'h0,
                   ($urandom_range(0, 3) == 0), "rnd_rd");
            end
         end
      end

      repeat (6) @(negedge clk);
      tests++;
      if (q0.size() != 0 || q1.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d/%0d responses outstanding, required 0/0",
                  q0.size(), q1.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
